hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl_if.sv | 33 +++
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - decode-stage hazard controller signal bundle
interface hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        branch_taken;
    logic        mc_start;
    logic        mc_done;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        mc_busy;
    logic        mc_timeout;
    logic [31:0] stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               branch_taken, mc_start, mc_done,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, mc_busy,
               mc_timeout, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               branch_taken, mc_start, mc_done,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, mc_busy,
               mc_timeout, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, branch flush and multi-cycle hold sequencer
// Optional stall-cycle counter enabled by defining HAZARD_CTRL_PERF_EN.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MC_TIMEOUT   = 64
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_MC_BUSY} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] MC_LAST    = 8'(MC_TIMEOUT - 1);

    state_t     r_state;
    logic [3:0] r_flush_cnt;
    logic [7:0] r_mc_cnt;
    logic       r_mc_timeout;

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_if_id_flush;
    logic w_id_ex_bubble;

    assign w_rs1_hit  = hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd);
    assign w_rs2_hit  = hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd);
    assign w_load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

    // Outputs follow state and live inputs so stalls and flushes take effect in the same cycle.
    always_comb begin
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_RUN: begin
                    if (hz.branch_taken) begin
                        w_if_id_flush  = 1'b1;
                        w_id_ex_bubble = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_write     = 1'b0;
                        w_if_id_write  = 1'b0;
                        w_id_ex_bubble = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    w_if_id_flush  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                end
                ST_MC_BUSY: begin
                    w_pc_write     = 1'b0;
                    w_if_id_write  = 1'b0;
                    w_id_ex_bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_flush_cnt  <= 4'd0;
            r_mc_cnt     <= 8'd0;
            r_mc_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (hz.branch_taken) begin
                        if (FLUSH_CYCLES > 1) begin
                            r_state     <= ST_FLUSH;
                            r_flush_cnt <= FLUSH_LOAD;
                        end
                    end else if (!w_load_use && hz.mc_start) begin
                        r_state  <= ST_MC_BUSY;
                        r_mc_cnt <= 8'd0;
                    end
                end
                ST_FLUSH: begin
                    r_flush_cnt <= r_flush_cnt - 4'd1;
                    if (r_flush_cnt == 4'd1) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_MC_BUSY: begin
                    if (hz.mc_done) begin
                        r_state <= ST_RUN;
                    end else if (r_mc_cnt == MC_LAST) begin
                        r_state      <= ST_RUN;
                        r_mc_timeout <= 1'b1;
                    end else begin
                        r_mc_cnt <= r_mc_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign hz.pc_write     = w_pc_write;
    assign hz.if_id_write  = w_if_id_write;
    assign hz.if_id_flush  = w_if_id_flush;
    assign hz.id_ex_bubble = w_id_ex_bubble;
    assign hz.mc_busy      = !rst && (r_state == ST_MC_BUSY);
    assign hz.mc_timeout   = r_mc_timeout;

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (!w_pc_write && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign hz.stall_cnt = r_stall_cnt;
`else
    assign hz.stall_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed and random stimulus
module tb_hazard_ctrl;
    localparam int FLUSH_CYCLES = 2;
    localparam int MC_TIMEOUT   = 8;

    logic clk;
    logic rst;
    hazard_ctrl_if hz ();

    hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .MC_TIMEOUT(MC_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pc_write;
        logic        if_id_write;
        logic        if_id_flush;
        logic        id_ex_bubble;
        logic        mc_busy;
        logic        mc_timeout;
        logic [31:0] stall_cnt;
        logic        regs_known;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // stimulus for the next cycle
    logic       s_rst, s_u1, s_u2, s_mr, s_br, s_ms, s_md;
    logic [4:0] s_rs1, s_rs2, s_rd;

    // reference model: remaining flush cycles, elapsed multi-cycle time, sticky flags
    int          m_flush_left = 0;
    bit          m_mc_active  = 0;
    int          m_mc_elapsed = 0;
    logic        m_timeout    = 1'b0;
    logic [31:0] m_stall      = 32'd0;
    bit          m_known      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic clr();
        s_rst = 0; s_u1 = 0; s_u2 = 0; s_mr = 0; s_br = 0; s_ms = 0; s_md = 0;
        s_rs1 = 0; s_rs2 = 0; s_rd = 0;
    endtask

    task automatic cyc();
        exp_t e;
        bit   lu;
        rst = s_rst;
        hz.id_rs1 = s_rs1; hz.id_rs2 = s_rs2; hz.id_uses_rs1 = s_u1; hz.id_uses_rs2 = s_u2;
        hz.ex_rd = s_rd; hz.ex_mem_read = s_mr; hz.branch_taken = s_br;
        hz.mc_start = s_ms; hz.mc_done = s_md;

        e.pc_write = 1; e.if_id_write = 1; e.if_id_flush = 0; e.id_ex_bubble = 0; e.mc_busy = 0;
        e.mc_timeout = m_timeout; e.stall_cnt = m_stall; e.regs_known = m_known;
        lu = s_mr && (s_rd != 0) && ((s_u1 && s_rs1 == s_rd) || (s_u2 && s_rs2 == s_rd));

        if (s_rst) begin
            q.push_back(e);
            m_flush_left = 0; m_mc_active = 0; m_mc_elapsed = 0;
            m_timeout = 0; m_stall = 0; m_known = 1;
        end else begin
            if (m_flush_left > 0) begin
                e.if_id_flush = 1; e.id_ex_bubble = 1;
                m_flush_left--;
            end else if (m_mc_active) begin
                e.mc_busy = 1; e.pc_write = 0; e.if_id_write = 0; e.id_ex_bubble = 1;
                if (s_md) m_mc_active = 0;
                else if (m_mc_elapsed == MC_TIMEOUT - 1) begin
                    m_mc_active = 0; m_timeout = 1;
                end else m_mc_elapsed++;
            end else if (s_br) begin
                e.if_id_flush = 1; e.id_ex_bubble = 1;
                m_flush_left = FLUSH_CYCLES - 1;
            end else if (lu) begin
                e.pc_write = 0; e.if_id_write = 0; e.id_ex_bubble = 1;
            end else if (s_ms) begin
                m_mc_active = 1; m_mc_elapsed = 0;
            end
            q.push_back(e);
`ifdef HAZARD_CTRL_PERF_EN
            if (!e.pc_write && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        clr();
        for (int i = 0; i < n; i++) cyc();
    endtask

    // monitor: one expected entry per cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("pc_write",     {31'd0, hz.pc_write},     {31'd0, e.pc_write});
                check("if_id_write",  {31'd0, hz.if_id_write},  {31'd0, e.if_id_write});
                check("if_id_flush",  {31'd0, hz.if_id_flush},  {31'd0, e.if_id_flush});
                check("id_ex_bubble", {31'd0, hz.id_ex_bubble}, {31'd0, e.id_ex_bubble});
                check("mc_busy",      {31'd0, hz.mc_busy},      {31'd0, e.mc_busy});
                if (e.regs_known) begin
                    check("mc_timeout", {31'd0, hz.mc_timeout}, {31'd0, e.mc_timeout});
                    check("stall_cnt",  hz.stall_cnt,           e.stall_cnt);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt;
        clr();
        rst = 1;
        hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_uses_rs1 = 0; hz.id_uses_rs2 = 0;
        hz.ex_rd = 0; hz.ex_mem_read = 0; hz.branch_taken = 0; hz.mc_start = 0; hz.mc_done = 0;
        @(posedge clk);
        #1;
        s_rst = 1; cyc(); cyc();
        idle(2);

        // load-use on rs1, then clears
        clr(); s_mr = 1; s_rd = 5; s_rs1 = 5; s_u1 = 1; cyc();
        idle(2);
        // no stall: rd=0, or rs1 not used
        clr(); s_mr = 1; s_rd = 0; s_rs1 = 0; s_u1 = 1; cyc();
        clr(); s_mr = 1; s_rd = 5; s_rs1 = 5; s_u1 = 0; cyc();
        // rs2 hit
        clr(); s_mr = 1; s_rd = 7; s_rs2 = 7; s_u2 = 1; cyc();
        idle(1);

        // branch flush; branch in the second flush cycle is ignored
        clr(); s_br = 1; cyc();
        clr(); s_br = 1; cyc();
        idle(3);

        // multi-cycle op with mc_done five cycles later
        clr(); s_ms = 1; cyc();
        idle(4);
        clr(); s_md = 1; cyc();
        idle(2);

        // mc_start suppressed by load-use then retried
        clr(); s_ms = 1; s_mr = 1; s_rd = 3; s_rs1 = 3; s_u1 = 1; cyc();
        clr(); s_ms = 1; cyc();
        clr(); s_md = 1; cyc();
        idle(2);

        // timeout, sticky flag
        clr(); s_ms = 1; cyc();
        idle(12);

        // branch + load-use + mc_start together: flush only
        clr(); s_br = 1; s_ms = 1; s_mr = 1; s_rd = 9; s_rs1 = 9; s_u1 = 1; cyc();
        idle(3);
        // reset in the middle of MC_BUSY
        clr(); s_ms = 1; cyc();
        idle(3);
        clr(); s_rst = 1; cyc();
        idle(3);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s_rst = ($urandom_range(0, 199) == 0);
            s_rs1 = 5'($urandom_range(0, 3));
            s_rs2 = 5'($urandom_range(0, 3));
            s_rd  = 5'($urandom_range(0, 3));
            s_u1  = ($urandom_range(0, 9) < 7);
            s_u2  = ($urandom_range(0, 9) < 5);
            s_mr  = ($urandom_range(0, 9) < 4);
            s_br  = ($urandom_range(0, 99) < 12);
            s_ms  = ($urandom_range(0, 99) < 20);
            s_md  = ($urandom_range(0, 99) < 10);
            cyc();
        end
        idle(2);

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
